agc_gain_control: RTL and testbench

Closes the AGC loop by consuming the RMS level measured on the sample stream and applying a digitally controlled gain to that stream. It sits downstream of the RMS measurement block in the AGC library. Each acoustic channel's ADC samples pass through a saturating fixed-point multiplier, and a small state machine steps the gain up or down toward a target RMS. A hold interval lets the RMS window refill between gain steps.

---
 rtl/agc_gain_control.sv | 143 ++++++++++++++
 tb/tb_agc_gain_control.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_control.sv
// AGC gain stage: saturating fixed-point multiplier on the sample stream
// with a step-and-hold FSM that walks the gain toward a target RMS.
module agc_gain_control #(
    parameter int WIDTH        = 16,
    parameter int GAIN_W       = 16,
    parameter int FRAC         = 12,
    parameter int GAIN_INIT    = 4096,
    parameter int GAIN_MIN     = 256,
    parameter int GAIN_MAX     = 65535,
    parameter int TARGET       = 8192,
    parameter int HYST         = 512,
    parameter int STEP_SHIFT   = 4,
    parameter int HOLD_SAMPLES = 512
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] s_TDATA,
    input  logic                    s_TVALID,
    input  logic        [WIDTH-1:0] rms_TDATA,
    input  logic                    rms_TVALID,
    output logic signed [WIDTH-1:0] m_TDATA,
    output logic                    m_TVALID,
    output logic       [GAIN_W-1:0] gain,
    output logic                    clip
);

    typedef enum logic [1:0] {IDLE, COMPARE, UPDATE, HOLD} state_t;

    localparam int PW = WIDTH + GAIN_W + 1;
    localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

    localparam logic [WIDTH:0]    HI_THR  = (WIDTH+1)'(TARGET + HYST);
    localparam logic [WIDTH:0]    LO_THR  = (WIDTH+1)'((TARGET > HYST) ? (TARGET - HYST) : 0);
    localparam logic [GAIN_W:0]   G_MIN_X = (GAIN_W+1)'(GAIN_MIN);
    localparam logic [GAIN_W:0]   G_MAX_X = (GAIN_W+1)'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] G_MIN   = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0] G_MAX   = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] G_INIT  = GAIN_W'(GAIN_INIT);
    localparam logic [HW-1:0]     HOLD_LD = HW'(HOLD_SAMPLES);

    state_t            state;
    logic [WIDTH-1:0]  rms_q;
    logic              is_high;
    logic              is_low;
    logic [HW-1:0]     hold_cnt;

    logic [GAIN_W-1:0] step_raw;
    logic [GAIN_W-1:0] step;
    logic [GAIN_W:0]   g_dn;
    logic [GAIN_W:0]   g_up;
    logic [GAIN_W-1:0] gain_dn;
    logic [GAIN_W-1:0] gain_up;

    assign step_raw = gain >> STEP_SHIFT;
    assign step     = (step_raw == '0) ? GAIN_W'(1) : step_raw;
    // one extra bit catches borrow on the way down and carry on the way up
    assign g_dn     = {1'b0, gain} - {1'b0, step};
    assign g_up     = {1'b0, gain} + {1'b0, step};
    assign gain_dn  = (g_dn[GAIN_W] || g_dn < G_MIN_X) ? G_MIN : g_dn[GAIN_W-1:0];
    assign gain_up  = (g_up > G_MAX_X) ? G_MAX : g_up[GAIN_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gain     <= G_INIT;
            rms_q    <= '0;
            is_high  <= 1'b0;
            is_low   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rms_TVALID) begin
                        rms_q <= rms_TDATA;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    is_high <= {1'b0, rms_q} > HI_THR;
                    is_low  <= {1'b0, rms_q} < LO_THR;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    if (is_high)
                        gain <= gain_dn;
                    else if (is_low)
                        gain <= gain_up;
                    hold_cnt <= HOLD_LD;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0)
                        state <= IDLE;
                    else if (s_TVALID)
                        hold_cnt <= hold_cnt - HW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic signed [WIDTH-1:0]  s1_data;
    logic        [GAIN_W-1:0] s1_gain;
    logic                     s1_valid;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     shifted;
    logic        [GAIN_W+1:0] top;
    logic                     ovf;
    logic signed [WIDTH-1:0]  sat_val;

    assign prod    = $signed({{(GAIN_W+1){s1_data[WIDTH-1]}}, s1_data})
                   * $signed({{(WIDTH+1){1'b0}}, s1_gain});
    assign shifted = prod >>> FRAC;
    // in range only when every bit above the output sign matches it
    assign top     = shifted[PW-1:WIDTH-1];
    assign ovf     = !((&top) || !(|top));
    assign sat_val = !ovf ? shifted[WIDTH-1:0]
                   : shifted[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                   : {1'b0, {(WIDTH-1){1'b1}}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_gain  <= '0;
            m_TVALID <= 1'b0;
            m_TDATA  <= '0;
            clip     <= 1'b0;
        end else begin
            s1_valid <= s_TVALID;
            if (s_TVALID) begin
                s1_data <= s_TDATA;
                s1_gain <= gain;
            end
            m_TVALID <= s1_valid;
            if (s1_valid) begin
                m_TDATA <= sat_val;
                clip    <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_agc_gain_control.sv
// Bench for agc_gain_control: random and directed stimulus against a
// cycle-level reference model of the gain loop and saturating multiplier.
module tb_agc_gain_control;

    localparam int HOLD  = 512;
    localparam int FRAC  = 12;
    localparam int SS    = 4;
    localparam int GMIN  = 256;
    localparam int GMAX  = 65535;
    localparam int GINIT = 4096;
    localparam int TGT   = 8192;
    localparam int HY    = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n = 1'b1;
    logic signed [15:0] s_TDATA = '0;
    logic               s_TVALID = 1'b0;
    logic        [15:0] rms_TDATA = '0;
    logic               rms_TVALID = 1'b0;
    logic signed [15:0] m_TDATA;
    logic               m_TVALID;
    logic        [15:0] gain;
    logic               clip;

    logic signed [15:0] s2_TDATA = '0;
    logic               s2_TVALID = 1'b0;
    logic        [15:0] rms2_TDATA = '0;
    logic               rms2_TVALID = 1'b0;
    logic signed [15:0] m2_TDATA;
    logic               m2_TVALID;
    logic        [15:0] gain2;
    logic               clip2;

    agc_gain_control dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_TDATA    (s_TDATA),
        .s_TVALID   (s_TVALID),
        .rms_TDATA  (rms_TDATA),
        .rms_TVALID (rms_TVALID),
        .m_TDATA    (m_TDATA),
        .m_TVALID   (m_TVALID),
        .gain       (gain),
        .clip       (clip)
    );

    agc_gain_control #(.STEP_SHIFT(12), .HOLD_SAMPLES(0)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_TDATA    (s2_TDATA),
        .s_TVALID   (s2_TVALID),
        .rms_TDATA  (rms2_TDATA),
        .rms_TVALID (rms2_TVALID),
        .m_TDATA    (m2_TDATA),
        .m_TVALID   (m2_TVALID),
        .gain       (gain2),
        .clip       (clip2)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int due;
        int d;
        bit c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   mg  = GINIT;
    int   ph  = 0;
    int   cd  = 0;
    int   rem = 0;
    int   rlat = 0;
    int   ed  = 0;
    bit   ec  = 1'b0;

    function automatic int next_gain(int g, int r, int ss, int gmin, int gmax);
        int st;
        int lo;
        st = g >> ss;
        if (st == 0) st = 1;
        lo = (TGT > HY) ? TGT - HY : 0;
        if (r > TGT + HY) return (g - st < gmin) ? gmin : g - st;
        if (r < lo) return (g + st > gmax) ? gmax : g + st;
        return g;
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic tick(input bit sv, input int sd, input bit rv, input int rd);
        longint p;
        int     d;
        bit     c;
        bit     ev;
        exp_t   e;
        s_TVALID   = sv;
        s_TDATA    = 16'(sd);
        rms_TVALID = rv;
        rms_TDATA  = 16'(rd);
        @(posedge clk);
        cyc++;
        if (reset_n) begin
            if (sv) begin
                p = (longint'(sd) * longint'(mg)) >>> FRAC;
                if (p > 32767) begin
                    d = 32767; c = 1'b1;
                end else if (p < -32768) begin
                    d = -32768; c = 1'b1;
                end else begin
                    d = int'(p); c = 1'b0;
                end
                q.push_back('{cyc + 1, d, c});
            end
            if (ph == 0) begin
                if (rv) begin
                    ph = 1; cd = 2; rlat = rd;
                end
            end else if (ph == 1) begin
                cd--;
                if (cd == 0) begin
                    mg  = next_gain(mg, rlat, SS, GMIN, GMAX);
                    rem = HOLD;
                    ph  = 2;
                end
            end else begin
                if (rem == 0) ph = 0;
                else if (sv) rem--;
            end
        end
        #1;
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e  = q.pop_front();
            ev = 1'b1;
            ed = e.d;
            ec = e.c;
        end
        check("m_TVALID", m_TVALID, ev);
        check("m_TDATA", m_TDATA, ed);
        check("clip", clip, ec);
        check("gain", gain, mg);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_gain", gain, GINIT);
        check("rst_valid", m_TVALID, 0);
        check("rst_data", m_TDATA, 0);
        check("rst_clip", clip, 0);
        q.delete();
        mg = GINIT; ph = 0; cd = 0; rem = 0; ed = 0; ec = 1'b0;
        repeat (3) tick(0, 0, 0, 0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        reset_n = 1'b0;
        #1;
        check("init_gain", gain, GINIT);
        check("init_valid", m_TVALID, 0);
        check("init_data", m_TDATA, 0);
        check("init_clip", clip, 0);
        repeat (2) tick(0, 0, 0, 0);
        #2;
        reset_n = 1'b1;

        tick(1, 1000, 0, 0);
        tick(1, -1000, 0, 0);
        check("pass_pos", m_TDATA, 1000);
        tick(1, 32767, 0, 0);
        check("pass_neg", m_TDATA, -1000);
        tick(0, 0, 0, 0);
        check("pass_max", m_TDATA, 32767);
        check("pass_clip", clip, 0);

        tick(0, 0, 1, 12000);
        repeat (600) tick(1, rnd_s(), 0, 0);
        check("step_down", gain, 3840);
        tick(0, 0, 1, 2000);
        repeat (600) tick(1, rnd_s(), 0, 0);
        check("step_up", gain, 4080);

        tick(0, 0, 1, 8000);
        repeat (10) tick(1, rnd_s(), 0, 0);
        check("deadband", gain, 4080);
        repeat (300) tick(1, rnd_s(), 1, 12000);
        check("hold_block", gain, 4080);
        repeat (300) tick(1, rnd_s(), 1, 12000);
        check("hold_release", gain, 3825);

        for (int i = 0; i < 30000 && mg != GMAX; i++)
            tick(1, rnd_s(), 1, 0);
        check("gain_max", gain, GMAX);
        tick(1, 30000, 0, 0);
        tick(1, -30000, 0, 0);
        check("sat_hi", m_TDATA, 32767);
        check("clip_hi", clip, 1);
        tick(0, 0, 0, 0);
        check("sat_lo", m_TDATA, -32768);
        check("clip_lo", clip, 1);

        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 3) != 0, rnd_s(),
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 16000)));

        for (int i = 0; i < 2000 && ph != 0; i++)
            tick(1, rnd_s(), 0, 0);
        tick(1, rnd_s(), 1, 20000);
        repeat (5) tick(1, rnd_s(), 0, 0);
        do_reset();
        repeat (4) tick(0, 0, 0, 0);
        check("post_rst_gain", gain, GINIT);
        tick(1, 1234, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        check("post_rst_data", m_TDATA, 1234);

        rms2_TDATA  = 16'(60000);
        rms2_TVALID = 1'b1;
        repeat (40) tick(0, 0, 0, 0);
        check("g2_unit_step", gain2, 4086);
        repeat (15960) tick(0, 0, 0, 0);
        check("g2_min", gain2, GMIN);
        repeat (20) tick(0, 0, 0, 0);
        check("g2_min_hold", gain2, GMIN);
        check("g2_out_idle", {m2_TVALID, clip2, m2_TDATA}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
